// File: rtl/estu_readout_argmax_if.sv
// estu_readout_argmax_if: beat stream in, argmax result out with valid/ready.
// Ports (signals):
//   i_start    start pulse: clear accumulators and begin collecting
//   i_valid    last-layer beat valid
//   i_data     signed membrane value (DATA_W bits)
//   o_busy     high while collecting or scanning
//   o_valid    result valid
//   i_ready    result consumer ready
//   o_class    winning neuron index
//   o_score    winning accumulated value (signed, ACC_W bits)
//   o_overflow sticky: an accumulator saturated this inference
//   o_drop     sticky: a beat arrived outside collection
// The slave modport is the readout block; the master modport is its driver.
interface estu_readout_argmax_if #(
    parameter int DATA_W = 13,
    parameter int ACC_W  = 18
);
    logic              i_start;
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_busy;
    logic              o_valid;
    logic              i_ready;
    logic [3:0]        o_class;
    logic [ACC_W-1:0]  o_score;
    logic              o_overflow;
    logic              o_drop;
    modport master (
        output i_start, i_valid, i_data, i_ready,
        input  o_busy, o_valid, o_class, o_score, o_overflow, o_drop
    );
    modport slave (
        input  i_start, i_valid, i_data, i_ready,
        output o_busy, o_valid, o_class, o_score, o_overflow, o_drop
    );
endinterface

// File: rtl/estu_readout_argmax.sv
// estu_readout_argmax: per-neuron accumulation over all timesteps, then argmax.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   bus      estu_readout_argmax_if slave: beat stream in, result handshake out
// Flow: IDLE -> COLLECT (N_OUT*N_TS beats) -> ARGMAX (N_OUT cycles) -> RESULT.
// The result registers load on the first RESULT cycle, so o_valid rises
// N_OUT+1 cycles after the edge that accepted the final beat.
module estu_readout_argmax #(
    parameter int N_OUT  = 10,
    parameter int N_TS   = 16,
    parameter int DATA_W = 13,
    parameter int ACC_W  = 18
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    estu_readout_argmax_if.slave  bus
);
    localparam int IDX_W = $clog2(N_OUT);
    localparam int TS_W  = N_TS > 1 ? $clog2(N_TS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, ARGMAX, RESULT} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc [N_OUT];
    logic [IDX_W-1:0]   nidx, scan, best_idx, cand_idx;
    logic [TS_W-1:0]    tsidx;
    logic [ACC_W-1:0]   acc_cur, acc_nxt, scan_val, best_val, cand_val, score_q;
    logic [ACC_W:0]     sum;
    logic [3:0]         class_q;
    logic               sat, take, last_beat, last_scan, valid_q, ovf_q, drop_q;

    // One guard bit above the accumulator detects overflow of the signed add;
    // on overflow the guard bit holds the true sign and selects the rail.
    always_comb begin
        last_beat = nidx == IDX_W'(N_OUT - 1) && tsidx == TS_W'(N_TS - 1);
        last_scan = scan == IDX_W'(N_OUT - 1);
        acc_cur   = acc[nidx];
        sum       = {acc_cur[ACC_W-1], acc_cur}
                  + {{(ACC_W + 1 - DATA_W){bus.i_data[DATA_W-1]}}, bus.i_data};
        sat       = sum[ACC_W] ^ sum[ACC_W-1];
        acc_nxt   = sat ? {sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
        scan_val  = acc[scan];
        // Index 0 seeds the best; strict > keeps the lower index on ties.
        take      = scan == '0 || $signed(scan_val) > $signed(best_val);
        cand_val  = take ? scan_val : best_val;
        cand_idx  = take ? scan : best_idx;
    end

    always_comb begin
        state_d = state_q;
        if (bus.i_start)
            state_d = COLLECT;
        else
            unique case (state_q)
                IDLE:    state_d = IDLE;
                COLLECT: state_d = bus.i_valid && last_beat ? ARGMAX : COLLECT;
                ARGMAX:  state_d = last_scan ? RESULT : ARGMAX;
                RESULT:  state_d = valid_q && bus.i_ready ? IDLE : RESULT;
                default: state_d = IDLE;
            endcase
    end

    always_ff @(posedge i_clk)
        state_q <= !i_rst_n ? IDLE : state_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_start) begin
            for (int i = 0; i < N_OUT; i++)
                acc[i] <= '0;
            nidx    <= '0;
            tsidx   <= '0;
            scan    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
            if (!i_rst_n) begin
                best_val <= '0;
                best_idx <= '0;
                class_q  <= '0;
                score_q  <= '0;
            end
        end else begin
            if (bus.i_valid && state_q != COLLECT)
                drop_q <= 1'b1;
            if (state_q == COLLECT && bus.i_valid) begin
                acc[nidx] <= acc_nxt;
                ovf_q     <= ovf_q | sat;
                nidx      <= nidx == IDX_W'(N_OUT - 1) ? '0 : nidx + 1'b1;
                if (nidx == IDX_W'(N_OUT - 1))
                    tsidx <= last_beat ? '0 : tsidx + 1'b1;
            end
            if (state_q == ARGMAX) begin
                best_val <= cand_val;
                best_idx <= cand_idx;
                scan     <= last_scan ? '0 : scan + 1'b1;
            end
            if (state_q == RESULT) begin
                if (!valid_q) begin
                    valid_q <= 1'b1;
                    class_q <= 4'(best_idx);
                    score_q <= best_val;
                end else if (bus.i_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.o_busy     = state_q == COLLECT || state_q == ARGMAX;
    assign bus.o_valid    = valid_q;
    assign bus.o_class    = class_q;
    assign bus.o_score    = score_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_drop     = drop_q;
endmodule

// File: tb/tb_estu_readout_argmax.sv
// tb_estu_readout_argmax: directed checks of the readout argmax at ACC_W=18 and ACC_W=14.
// Both instances see identical stimulus; the 14-bit one exercises saturation.
module tb_estu_readout_argmax;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [12:0] data = '0;
    logic [12:0] pat [10];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 i_clk = ~i_clk;

    estu_readout_argmax_if #(.DATA_W(13), .ACC_W(18)) a_if ();
    estu_readout_argmax_if #(.DATA_W(13), .ACC_W(14)) s_if ();

    assign a_if.i_start = start;
    assign a_if.i_valid = valid;
    assign a_if.i_data  = data;
    assign a_if.i_ready = ready;
    assign s_if.i_start = start;
    assign s_if.i_valid = valid;
    assign s_if.i_data  = data;
    assign s_if.i_ready = ready;

    estu_readout_argmax #(.N_OUT(10), .N_TS(16), .DATA_W(13), .ACC_W(18)) u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (a_if.slave)
    );

    estu_readout_argmax #(.N_OUT(10), .N_TS(16), .DATA_W(13), .ACC_W(14)) u_sat (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (s_if.slave)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic set_pat(input int hot_a, input int hot_b, input int hv, input int cv);
        for (int i = 0; i < 10; i++)
            pat[i] = 13'((i == hot_a || i == hot_b) ? hv : cv);
    endtask

    task automatic beat(input logic [12:0] d);
        valid = 1'b1;
        data  = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends 16 timesteps of pat, then counts cycles until o_valid rises.
    task automatic collect(input string tag);
        int cnt;
        for (int t = 0; t < 16; t++)
            for (int n = 0; n < 10; n++)
                beat(pat[n]);
        cnt = 0;
        while (!a_if.o_valid && cnt < 50) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, cnt, 11);
    endtask

    task automatic expect_result(input string tag, input int cls, input int a_score,
                                 input int s_score, input int s_ovf);
        check({tag, "_valid"}, a_if.o_valid, 1);
        check({tag, "_class"}, a_if.o_class, cls);
        check({tag, "_score"}, $signed(a_if.o_score), a_score);
        check({tag, "_ovf"}, a_if.o_overflow, 0);
        check({tag, "_s_valid"}, s_if.o_valid, 1);
        check({tag, "_s_class"}, s_if.o_class, cls);
        check({tag, "_s_score"}, $signed(s_if.o_score), s_score);
        check({tag, "_s_ovf"}, s_if.o_overflow, s_ovf);
    endtask

    task automatic ack(input string tag);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check({tag, "_ack_valid"}, a_if.o_valid, 0);
        check({tag, "_ack_busy"}, a_if.o_busy, 0);
    endtask

    initial begin
        // Reset held for 3 cycles while beats toggle.
        for (int i = 0; i < 3; i++) begin
            valid = ~valid;
            data  = 13'd123;
            tick();
        end
        check("rst_busy", a_if.o_busy, 0);
        check("rst_valid", a_if.o_valid, 0);
        check("rst_class", a_if.o_class, 0);
        check("rst_score", $signed(a_if.o_score), 0);
        check("rst_ovf", a_if.o_overflow, 0);
        check("rst_drop", a_if.o_drop, 0);
        check("rst_s_drop", s_if.o_drop, 0);
        valid   = 1'b0;
        i_rst_n = 1'b1;
        tick();
        tick();
        check("rst_rel_drop", a_if.o_drop, 0);
        check("rst_rel_busy", a_if.o_busy, 0);

        // Neuron 7 dominant; consumer stalls 5 cycles.
        set_pat(7, 7, 100, 10);
        pulse_start();
        check("a_busy", a_if.o_busy, 1);
        collect("a");
        expect_result("a", 7, 1600, 1600, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("a_hold_valid", a_if.o_valid, 1);
            check("a_hold_class", a_if.o_class, 7);
            check("a_hold_score", $signed(a_if.o_score), 1600);
        end
        ack("a");

        // Tie between neurons 2 and 5 resolves to the lower index.
        set_pat(2, 5, 50, -3);
        pulse_start();
        collect("tie");
        expect_result("tie", 2, 800, 800, 0);
        ack("tie");

        // Most negative beats: 14-bit accumulators pin at -8192.
        set_pat(0, 0, -4096, -4096);
        pulse_start();
        collect("sat");
        expect_result("sat", 0, -65536, -8192, 1);
        ack("sat");
        check("sat_ovf_sticky", s_if.o_overflow, 1);

        // Beat in IDLE sets drop; start with a beat discards it and clears drop.
        beat(13'd1000);
        check("idle_drop", a_if.o_drop, 1);
        start = 1'b1;
        valid = 1'b1;
        data  = 13'd1000;
        tick();
        start = 1'b0;
        valid = 1'b0;
        check("start_beat_drop", a_if.o_drop, 0);
        check("start_ovf_clr", s_if.o_overflow, 0);
        set_pat(3, 3, 30, 29);
        collect("drop");
        expect_result("drop", 3, 480, 480, 0);
        check("drop_clean", a_if.o_drop, 0);
        ack("drop");

        // Restart mid-collection after 37 beats; only the second run counts.
        pulse_start();
        for (int i = 0; i < 37; i++)
            beat(13'd900);
        pulse_start();
        set_pat(9, 9, 7, -7);
        collect("restart");
        expect_result("restart", 9, 112, 112, 0);
        beat(13'd5);
        check("result_drop", a_if.o_drop, 1);
        check("result_drop_class", a_if.o_class, 9);
        ack("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/estu_readout_argmax.md
Name: estu_readout_argmax

Overview:
- Consumes the ESTU last-layer output stream: one valid beat per output neuron per timestep, carrying a 13-bit signed membrane value.
- Accumulates each neuron's values across all timesteps of one inference, then scans the sums to find the largest.
- Presents the winning class index and its score on a valid/ready handshake to the SoC-side register/UART path.
- Sits directly downstream of servant_estu's valid_last_layer / data_last_layer outputs.

Parameters:
- N_OUT, 10, number of output neurons (beats per timestep), 2..16
- N_TS, 16, timesteps per inference
- DATA_W, 13, width of the input beat (two's complement)
- ACC_W, 18, accumulator width (signed), >= DATA_W+1

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  single-cycle pulse: clear accumulators, begin collecting
- i_valid  in  1  last-layer beat valid (pulse, one cycle per beat)
- i_data  in  DATA_W  signed membrane value of the current neuron
- o_busy  out  1  high in COLLECT and ARGMAX
- o_valid  out  1  result valid
- i_ready  in  1  result consumer ready
- o_class  out  4  winning neuron index
- o_score  out  ACC_W  winning accumulated value (signed)
- o_overflow  out  1  sticky: some accumulator saturated this inference
- o_drop  out  1  sticky: beat arrived outside COLLECT

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - state IDLE; all outputs 0; accumulators 0; counters 0.
- States: IDLE, COLLECT, ARGMAX, RESULT.
- i_start has priority in every state. On the edge where it is seen:
  - zero all accumulators and the neuron/timestep counters;
  - clear o_valid, o_overflow and o_drop;
  - go to COLLECT.
  - A simultaneous i_valid beat is discarded, and o_drop is not set for it.
- COLLECT:
  - Each i_valid beat adds sign-extended i_data to acc[nidx].
  - nidx increments per beat; at N_OUT-1 it wraps to 0 and tsidx increments.
  - Addition saturates at +(2^(ACC_W-1)-1) and -2^(ACC_W-1); any saturation sets o_overflow.
  - The beat with nidx=N_OUT-1 and tsidx=N_TS-1 moves the block to ARGMAX on the next cycle.
- ARGMAX:
  - Runs exactly N_OUT cycles, scanning index 0..N_OUT-1 one per cycle.
  - Comparison is signed greater-than. Ties go to the lower index (strict > replaces the best).
  - Best value initialises from acc[0].
  - After the last index the block enters RESULT with o_class/o_score registered.
  - o_valid rises N_OUT+1 cycles after the edge that accepted the final beat.
- RESULT:
  - o_valid, o_class and o_score are held stable until the edge where o_valid & i_ready; then o_valid=0 and state IDLE.
  - o_overflow/o_drop remain until the next i_start or reset.
- o_drop: an i_valid beat in IDLE, ARGMAX or RESULT (without i_start) is ignored and sets o_drop.
- o_busy = (state==COLLECT) | (state==ARGMAX).
- Reset mid-operation: the block returns to IDLE on the next edge and partial sums are lost.
- Fully synchronous; no combinational path from i_valid/i_data to any output. i_ready may gate the o_valid clear only.

Test Plan:
- Reset with i_rst_n=0 for 3 cycles, with i_valid toggling → all outputs 0, o_drop stays 0 after release.
- i_start, then 16 timesteps × 10 beats where neuron 7 = +100 and the others = +10 → o_class=7, o_score=1600. o_valid rises exactly 11 cycles after the last beat. With i_ready held low for 5 cycles, outputs are stable and then clear.
- Tie: neurons 2 and 5 both get +50/timestep, the others -3 → o_class=2, o_score=800.
- All beats = -4096 with ACC_W=14 → accumulators saturate at -8192, o_overflow=1, o_class=0, o_score=-8192.
- Beat in IDLE → o_drop=1, and the accumulators are unaffected by it on a subsequent i_start inference. i_start together with a beat → beat discarded, o_drop stays 0.
- i_start asserted mid-COLLECT (after 37 beats), then a full clean inference → the result reflects only the second inference.
